// File: rtl/irq_pkg.sv
// Shared register map and constants for the interrupt controller.
package irq_pkg;

  typedef enum logic [1:0] {
    IRQ_PENDING = 2'd0,
    IRQ_ENABLE  = 2'd1,
    IRQ_EDGE    = 2'd2,
    IRQ_CLAIM   = 2'd3
  } irq_reg_e;

  // CLAIM read value when no source is active.
  localparam logic [31:0] IRQ_NONE = 32'hFFFF_FFFF;

endpackage

// File: rtl/irq_ctrl_if.sv
// Register port of the interrupt controller, hung off the memory bus decoder.
interface irq_ctrl_if;
  logic [1:0]  reg_addr;
  logic        reg_rd;
  logic        reg_wr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;

  modport master (output reg_addr, reg_rd, reg_wr, reg_wdata, input reg_rdata);
  modport slave  (input reg_addr, reg_rd, reg_wr, reg_wdata, output reg_rdata);
endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder; src[0] has the highest priority.
module irq_prio_enc #(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0] req,
  output logic               valid,
  output logic [ID_W-1:0]    id
);

  // Scan high to low so the lowest set index is the last one assigned.
  always_comb begin
    valid = 1'b0;
    id    = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        id    = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: edge/level capture, enable mask, priority select,
// memory-mapped PENDING/ENABLE/EDGE_MODE/CLAIM registers, drives cu.hwint.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src,
  irq_ctrl_if.slave          bus,
  output logic               hwint,
  output logic [ID_W-1:0]    irq_id
);

  logic [NUM_SRC-1:0] pend_q, pend_d, en_q, en_d, edge_q, edge_d, prev_q, prev_d;
  logic [NUM_SRC-1:0] w1c, claim_clr, active, wmask;
  logic [31:0]        rdata_q, rdata_d;
  logic               hwint_q, hwint_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               enc_valid;
  logic [ID_W-1:0]    enc_id;
  irq_reg_e           addr;

  // Register contents are NUM_SRC wide; upper bus bits read as zero.
  function automatic logic [31:0] zext(input logic [NUM_SRC-1:0] v);
    logic [31:0] r;
    r              = '0;
    r[NUM_SRC-1:0] = v;
    return r;
  endfunction

  assign addr   = irq_reg_e'(bus.reg_addr);
  assign wmask  = bus.reg_wdata[NUM_SRC-1:0];
  assign active = pend_q & en_q;

  // One encoder serves both the irq_id output and CLAIM reads.
  irq_prio_enc #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) u_enc (
    .req   (active),
    .valid (enc_valid),
    .id    (enc_id)
  );

  // Next-state: register writes, reads/claim, pending capture, output regs.
  always_comb begin
    en_d      = en_q;
    edge_d    = edge_q;
    rdata_d   = rdata_q;
    prev_d    = src;
    w1c       = '0;
    claim_clr = '0;
    if (bus.reg_wr) begin
      // A write strobe suppresses any concurrent read.
      unique case (addr)
        IRQ_PENDING: w1c    = wmask;
        IRQ_ENABLE:  en_d   = wmask;
        IRQ_EDGE:    edge_d = wmask;
        IRQ_CLAIM:   ;
      endcase
    end else if (bus.reg_rd) begin
      unique case (addr)
        IRQ_PENDING: rdata_d = zext(pend_q);
        IRQ_ENABLE:  rdata_d = zext(en_q);
        IRQ_EDGE:    rdata_d = zext(edge_q);
        IRQ_CLAIM: begin
          rdata_d = enc_valid ? 32'(enc_id) : IRQ_NONE;
          if (enc_valid) claim_clr = NUM_SRC'(1) << enc_id;
        end
      endcase
    end
    // Mode used is the one in force this cycle; a mode change applies next cycle.
    for (int i = 0; i < NUM_SRC; i++) begin
      if (edge_q[i])
        pend_d[i] = (src[i] & ~prev_q[i]) | (pend_q[i] & ~(w1c[i] | claim_clr[i]));
      else
        pend_d[i] = src[i];
    end
    hwint_d = enc_valid;
    id_d    = enc_valid ? enc_id : '0;
  end

  // State and output flops; prev_src keeps tracking src through reset.
  always_ff @(posedge clk) begin
    prev_q <= prev_d;
    if (rst) begin
      pend_q  <= '0;
      en_q    <= '0;
      edge_q  <= '0;
      rdata_q <= '0;
      hwint_q <= 1'b0;
      id_q    <= '0;
    end else begin
      pend_q  <= pend_d;
      en_q    <= en_d;
      edge_q  <= edge_d;
      rdata_q <= rdata_d;
      hwint_q <= hwint_d;
      id_q    <= id_d;
    end
  end

  assign bus.reg_rdata = rdata_q;
  assign hwint         = hwint_q;
  assign irq_id        = id_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl with a per-cycle reference model.
module tb_irq_ctrl;
  import irq_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] src;
  logic       hwint;
  logic [2:0] irq_id;

  irq_ctrl_if bus ();

  irq_ctrl #(.NUM_SRC(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .src    (src),
    .bus    (bus.slave),
    .hwint  (hwint),
    .irq_id (irq_id)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit [7:0]  m_pend, m_en, m_edge, m_prev;
  bit [31:0] m_rdata;
  bit        m_hwint;
  int        m_id;
  bit        m_ok = 1'b0;

  function automatic int first_set(input bit [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Model advances on each rising edge from the inputs present at that edge.
  always @(posedge clk) begin
    bit [7:0] act, clr, nxt, nen, nedge;
    int top;
    if (rst) begin
      m_prev = src; m_pend = 0; m_en = 0; m_edge = 0;
      m_rdata = 0; m_hwint = 0; m_id = 0; m_ok = 1'b1;
    end else begin
      act = m_pend & m_en;
      top = first_set(act);
      clr = 0; nen = m_en; nedge = m_edge;
      if (bus.reg_wr) begin
        if (bus.reg_addr == 2'd0) clr = bus.reg_wdata[7:0];
        if (bus.reg_addr == 2'd1) nen = bus.reg_wdata[7:0];
        if (bus.reg_addr == 2'd2) nedge = bus.reg_wdata[7:0];
      end else if (bus.reg_rd) begin
        case (bus.reg_addr)
          2'd0: m_rdata = {24'd0, m_pend};
          2'd1: m_rdata = {24'd0, m_en};
          2'd2: m_rdata = {24'd0, m_edge};
          default: begin
            if (top < 0) m_rdata = 32'hFFFF_FFFF;
            else begin m_rdata = top; clr[top] = 1'b1; end
          end
        endcase
      end
      for (int i = 0; i < 8; i++)
        nxt[i] = m_edge[i] ? ((src[i] && !m_prev[i]) || (m_pend[i] && !clr[i])) : src[i];
      m_pend  = nxt;
      m_en    = nen;
      m_edge  = nedge;
      m_hwint = (act != 0);
      m_id    = (top < 0) ? 0 : top;
      m_prev  = src;
    end
  end

  // Every falling edge: DUT outputs against the model.
  always @(negedge clk) begin
    if (m_ok) begin
      checks += 3;
      if (hwint !== m_hwint) begin
        errors++; $display("FAIL model_hwint t=%0t got %0b want %0b", $time, hwint, m_hwint);
      end
      if (irq_id !== 3'(m_id)) begin
        errors++; $display("FAIL model_irq_id t=%0t got %0d want %0d", $time, irq_id, m_id);
      end
      if (bus.reg_rdata !== m_rdata) begin
        errors++; $display("FAIL model_rdata t=%0t got %h want %h", $time, bus.reg_rdata, m_rdata);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL %s got %h want %h", name, got, exp);
    end
  endtask

  // All tasks start and end on a falling edge.
  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    bus.reg_addr = a; bus.reg_wdata = d; bus.reg_wr = 1'b1;
    @(negedge clk);
    bus.reg_wr = 1'b0;
  endtask

  task automatic rd_reg(input string name, input logic [1:0] a, input logic [31:0] exp);
    bus.reg_addr = a; bus.reg_rd = 1'b1;
    @(negedge clk);
    bus.reg_rd = 1'b0;
    chk(name, bus.reg_rdata, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; src = 8'h01;
    bus.reg_addr = 2'd0; bus.reg_rd = 1'b0; bus.reg_wr = 1'b0; bus.reg_wdata = '0;
    idle(3);
    chk("reset_hwint", 32'(hwint), 0);
    chk("reset_irq_id", 32'(irq_id), 0);
    chk("reset_rdata", bus.reg_rdata, 0);
    rst = 1'b0;

    // 1: src[0] held high: after clearing the level-captured bit, no edge appears.
    wr_reg(IRQ_EDGE, 32'hFF);
    wr_reg(IRQ_ENABLE, 32'hFF);
    wr_reg(IRQ_PENDING, 32'hFF);
    idle(2);
    chk("held_line_hwint", 32'(hwint), 0);
    rd_reg("held_line_pending", IRQ_PENDING, 32'h0);

    // 2: single edge on src[5]
    src = 8'h00; idle(1);
    src = 8'h20; @(negedge clk);
    src = 8'h00; @(negedge clk);
    chk("edge_hwint", 32'(hwint), 1);
    chk("edge_irq_id", 32'(irq_id), 5);
    rd_reg("edge_pending", IRQ_PENDING, 32'h20);
    rd_reg("edge_claim", IRQ_CLAIM, 32'd5);
    rd_reg("edge_pending_after_claim", IRQ_PENDING, 32'h0);
    chk("edge_hwint_after_claim", 32'(hwint), 0);

    // 3: priority between bits 2 and 6
    src = 8'h44; @(negedge clk);
    src = 8'h00; @(negedge clk);
    chk("prio_irq_id", 32'(irq_id), 2);
    rd_reg("prio_claim0", IRQ_CLAIM, 32'd2);
    rd_reg("prio_claim1", IRQ_CLAIM, 32'd6);
    rd_reg("prio_claim_none", IRQ_CLAIM, IRQ_NONE);

    // 4: level mode on src[3]
    wr_reg(IRQ_EDGE, 32'h00);
    wr_reg(IRQ_ENABLE, 32'h08);
    src = 8'h08; idle(2);
    rd_reg("level_claim0", IRQ_CLAIM, 32'd3);
    rd_reg("level_claim1", IRQ_CLAIM, 32'd3);
    rd_reg("level_pending", IRQ_PENDING, 32'h08);
    chk("level_hwint", 32'(hwint), 1);
    src = 8'h00; @(negedge clk);
    chk("level_drop_hwint_lag", 32'(hwint), 1);
    @(negedge clk);
    chk("level_drop_hwint", 32'(hwint), 0);

    // 5: W1C collides with a rising edge; set wins
    wr_reg(IRQ_EDGE, 32'hFF);
    wr_reg(IRQ_ENABLE, 32'h00);
    src = 8'h10;
    wr_reg(IRQ_PENDING, 32'h10);
    src = 8'h00;
    rd_reg("collide_pending", IRQ_PENDING, 32'h10);
    wr_reg(IRQ_PENDING, 32'hFF);
    rd_reg("collide_cleared", IRQ_PENDING, 32'h00);

    // 6: masked pending, then enable
    src = 8'h01; @(negedge clk);
    src = 8'h00; idle(2);
    chk("mask_hwint", 32'(hwint), 0);
    rd_reg("mask_claim", IRQ_CLAIM, IRQ_NONE);
    rd_reg("mask_pending", IRQ_PENDING, 32'h01);
    wr_reg(IRQ_ENABLE, 32'h01);
    chk("unmask_hwint_lag", 32'(hwint), 0);
    @(negedge clk);
    chk("unmask_hwint", 32'(hwint), 1);
    chk("unmask_irq_id", 32'(irq_id), 0);

    // 7: read+write same cycle -> write only, rdata holds
    bus.reg_addr = IRQ_ENABLE; bus.reg_wdata = 32'hA5; bus.reg_wr = 1'b1; bus.reg_rd = 1'b1;
    @(negedge clk);
    bus.reg_wr = 1'b0; bus.reg_rd = 1'b0;
    chk("rdwr_rdata_holds", bus.reg_rdata, 32'h01);
    rd_reg("rdwr_enable", IRQ_ENABLE, 32'hA5);

    // 8: reset during a read
    bus.reg_addr = IRQ_ENABLE; bus.reg_rd = 1'b1; rst = 1'b1;
    @(negedge clk);
    bus.reg_rd = 1'b0; rst = 1'b0;
    chk("rst_read_rdata", bus.reg_rdata, 32'h0);
    chk("rst_read_hwint", 32'(hwint), 0);
    rd_reg("rst_enable", IRQ_ENABLE, 32'h0);
    rd_reg("rst_edge", IRQ_EDGE, 32'h0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
